mem_loader: RTL and testbench



---
 rtl/mem_loader_pkg.sv | 33 +++
 rtl/mem_loader.sv | 144 ++++++++++++++
 tb/tb_mem_loader.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding and frame header layout.
// Optional trailing-checksum support is enabled with MEM_LOADER_CHECKSUM_EN.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_ADDR = 3'd0,
        HDR_LEN  = 3'd1,
        LOAD     = 3'd2,
`ifdef MEM_LOADER_CHECKSUM_EN
        CHECK    = 3'd3,
`endif
        RUN      = 3'd4,
        ERROR    = 3'd5
    } ldr_state_t;

    // Header word field positions within the 32-bit stream word.
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 32;

    function automatic logic accepts_words(input ldr_state_t s);
        logic acc;
        case (s)
            HDR_ADDR, HDR_LEN, LOAD: acc = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            CHECK:                   acc = 1'b1;
`endif
            default:                 acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot loader: receives {start address, word count, payload} over valid/ready, writes blram,
// then hands the blram port to the CPU. MEM_LOADER_CHECKSUM_EN adds a trailing checksum word.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_LEN  = 14,
    parameter int MEM_DEPTH = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_data,
    input  logic                cpu_wrEn,
    input  logic [ADDR_LEN-1:0] cpu_addr,
    input  logic [31:0]         cpu_data,
    output logic                o_we,
    output logic [ADDR_LEN-1:0] o_addr,
    output logic [31:0]         o_data,
    output logic                o_cpu_rst,
    output logic                o_done,
    output logic                o_error
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam ldr_state_t POST_LOAD = CHECK;
`else
    localparam ldr_state_t POST_LOAD = RUN;
`endif

    ldr_state_t          state_reg, state_next;
    logic [ADDR_LEN-1:0] ptr_reg, ptr_next;
    logic [31:0]         count_reg, count_next;
    logic                we_reg, we_next;
    logic [ADDR_LEN-1:0] waddr_reg, waddr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic                ready_reg;
    logic                done_reg;
    logic                cpu_rst_reg;
    logic                xfer;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_reg, sum_next;
`endif

    assign xfer = i_valid & ready_reg;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        we_next    = 1'b0;
        waddr_next = waddr_reg;
        wdata_next = wdata_reg;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_next   = sum_reg;
`endif
        case (state_reg)
            HDR_ADDR: begin
`ifdef MEM_LOADER_CHECKSUM_EN
                sum_next = 32'd0;
`endif
                if (xfer) begin
                    ptr_next   = i_data[HDR_ADDR_LSB +: ADDR_LEN];
                    state_next = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (xfer) begin
                    count_next = i_data[HDR_LEN_LSB +: HDR_LEN_W];
                    if (i_data > DEPTH_W)
                        state_next = ERROR;
                    else if (i_data == 32'd0)
                        state_next = POST_LOAD;
                    else
                        state_next = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    we_next    = 1'b1;
                    waddr_next = ptr_reg;
                    wdata_next = i_data;
                    // Pointer width equals log2(MEM_DEPTH), so it wraps naturally.
                    ptr_next   = ptr_reg + ADDR_LEN'(1);
                    count_next = count_reg - 32'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_next   = sum_reg + i_data;
`endif
                    if (count_reg == 32'd1)
                        state_next = POST_LOAD;
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer)
                    state_next = (i_data == sum_reg) ? RUN : ERROR;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= HDR_ADDR;
            ptr_reg     <= '0;
            count_reg   <= '0;
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
            cpu_rst_reg <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            count_reg   <= count_next;
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
            ready_reg   <= accepts_words(state_next);
            // Release lags RUN entry by one edge so the final load write completes first.
            done_reg    <= (state_reg == RUN);
            cpu_rst_reg <= (state_reg != RUN);
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_reg     <= sum_next;
`endif
        end
    end

    assign o_ready   = ready_reg;
    assign o_we      = done_reg ? cpu_wrEn : we_reg;
    assign o_addr    = done_reg ? cpu_addr : waddr_reg;
    assign o_data    = done_reg ? cpu_data : wdata_reg;
    assign o_cpu_rst = cpu_rst_reg;
    assign o_done    = done_reg;
    assign o_error   = (state_reg == ERROR);

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of frames plus hand-written reset-abort sequence.
// Checksum trailer cases are exercised when MEM_LOADER_CHECKSUM_EN is defined.
module tb_mem_loader;

    localparam int ADDR_LEN  = 14;
    localparam int MEM_DEPTH = 16384;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic [31:0]         i_data = '0;
    logic                cpu_wrEn = 1'b0;
    logic [ADDR_LEN-1:0] cpu_addr = '0;
    logic [31:0]         cpu_data = '0;
    logic                o_we;
    logic [ADDR_LEN-1:0] o_addr;
    logic [31:0]         o_data;
    logic                o_cpu_rst;
    logic                o_done;
    logic                o_error;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_LEN(ADDR_LEN), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
        .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_error(o_error)
    );

    // blram stand-in: captures loader writes only
    logic [31:0] mem_model [MEM_DEPTH] = '{default: 32'd0};
    int          total_writes = 0;
    int          spurious = 0;
    logic        xfer_d = 1'b0;

    always @(posedge clk) begin
        if (o_we && !o_done) begin
            mem_model[o_addr] <= o_data;
            total_writes      <= total_writes + 1;
            if (!xfer_d)
                spurious <= spurious + 1;
        end
        xfer_d <= i_valid & o_ready & ~rst;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]       addr;
        logic [31:0]       len;
        int                nsend;
        logic [3:0][31:0]  w;
        bit                gap;
        bit                bad_trailer;
        bit                exp_err;
        logic [13:0]       a0;
        logic [31:0]       d0;
        logic [13:0]       a1;
        logic [31:0]       d1;
        logic [13:0]       a2;
        logic [31:0]       d2;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] len, input int nsend,
                                input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                                input bit gap, input bit bad, input bit err,
                                input logic [13:0] a0, input logic [31:0] d0,
                                input logic [13:0] a1, input logic [31:0] d1,
                                input logic [13:0] a2, input logic [31:0] d2);
        vec_t v;
        v.addr = addr; v.len = len; v.nsend = nsend;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = 32'd0;
        v.gap = gap; v.bad_trailer = bad; v.exp_err = err;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
        return v;
    endfunction

    task automatic send_word(input logic [31:0] w, input bit gap, input string name);
        bit ok;
        if (gap) begin
            i_valid = 1'b0;
            @(negedge clk);
        end
        i_valid = 1'b1;
        i_data  = w;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (o_ready) ok = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: handshake timeout got o_ready=0 expected 1", name);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        cpu_wrEn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",   32'(o_ready),   32'd0);
        check("rst_we",      32'(o_we),      32'd0);
        check("rst_addr",    32'(o_addr),    32'd0);
        check("rst_data",    o_data,         32'd0);
        check("rst_cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("rst_done",    32'(o_done),    32'd0);
        check("rst_error",   32'(o_error),   32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(o_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t        v;
        int          base;
        logic [31:0] sum;
        logic [13:0] la;
        bit          ok;

        vecs.push_back(mk(32'd100, 32'd3, 3, 32'd7, 32'd8, 32'd9, 1'b0, 1'b0, 1'b0,
                          14'd100, 32'd7, 14'd101, 32'd8, 14'd102, 32'd9));
        vecs.push_back(mk(32'd110, 32'd3, 3, 32'd7, 32'd8, 32'd9, 1'b1, 1'b0, 1'b0,
                          14'd110, 32'd7, 14'd111, 32'd8, 14'd112, 32'd9));
        // upper address bits set, must be ignored; wraps 16383 -> 0
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd2, 2, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0,
                          14'd16383, 32'd5, 14'd0, 32'd6, 14'd1, 32'd0));
        vecs.push_back(mk(32'd50, 32'd16385, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1,
                          14'd50, 32'd0, 14'd51, 32'd0, 14'd52, 32'd0));
        vecs.push_back(mk(32'd10, 32'd0, 0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                          14'd10, 32'd0, 14'd11, 32'd0, 14'd12, 32'd0));
`ifdef MEM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(32'd400, 32'd2, 2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0,
                          14'd400, 32'd1, 14'd401, 32'd2, 14'd402, 32'd0));
        vecs.push_back(mk(32'd410, 32'd2, 2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1'b1,
                          14'd410, 32'd1, 14'd411, 32'd2, 14'd412, 32'd0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            do_reset();
            base = total_writes;
            send_word(v.addr, v.gap, "hdr_addr");
            send_word(v.len, v.gap, "hdr_len");
            sum = 32'd0;
            for (int j = 0; j < v.nsend; j++) begin
                send_word(v.w[j], v.gap, "payload");
                sum = sum + v.w[j];
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            if (!v.exp_err || v.bad_trailer)
                send_word(sum + 32'(v.bad_trailer), v.gap, "trailer");
`endif
            // now in the cycle after the final transfer
            check($sformatf("v%0d_ready_n1", i),   32'(o_ready),   32'd0);
            check($sformatf("v%0d_cpurst_n1", i),  32'(o_cpu_rst), 32'd1);
            check($sformatf("v%0d_done_n1", i),    32'(o_done),    32'd0);
            check($sformatf("v%0d_error_n1", i),   32'(o_error),   32'(v.exp_err));
`ifndef MEM_LOADER_CHECKSUM_EN
            if (v.nsend > 0) begin
                la = v.addr[13:0] + 14'(v.nsend - 1);
                check($sformatf("v%0d_last_we", i),   32'(o_we),   32'd1);
                check($sformatf("v%0d_last_addr", i), 32'(o_addr), 32'(la));
                check($sformatf("v%0d_last_data", i), o_data,      v.w[v.nsend-1]);
            end
`endif
            @(negedge clk);
            check($sformatf("v%0d_ready_n2", i),  32'(o_ready),   32'd0);
            check($sformatf("v%0d_cpurst_n2", i), 32'(o_cpu_rst), 32'(v.exp_err));
            check($sformatf("v%0d_done_n2", i),   32'(o_done),    32'(!v.exp_err));
            check($sformatf("v%0d_error_n2", i),  32'(o_error),   32'(v.exp_err));
            check($sformatf("v%0d_we_n2", i),     32'(o_we),      32'd0);

            cpu_wrEn = 1'b1;
            cpu_addr = 14'(1000 + i);
            cpu_data = 32'hC0DE_0000 + 32'(i);
            #1;
            if (v.exp_err) begin
                check($sformatf("v%0d_err_we_blocked", i), 32'(o_we), 32'd0);
            end else begin
                check($sformatf("v%0d_pass_we", i),   32'(o_we),   32'd1);
                check($sformatf("v%0d_pass_addr", i), 32'(o_addr), 32'(1000 + i));
                check($sformatf("v%0d_pass_data", i), o_data,      32'hC0DE_0000 + 32'(i));
            end
            @(negedge clk);
            cpu_wrEn = 1'b0;

            check($sformatf("v%0d_mem0", i), mem_model[v.a0], v.d0);
            check($sformatf("v%0d_mem1", i), mem_model[v.a1], v.d1);
            check($sformatf("v%0d_mem2", i), mem_model[v.a2], v.d2);
            check($sformatf("v%0d_nwrites", i), 32'(total_writes - base), 32'(v.nsend));
            check($sformatf("v%0d_spurious", i), 32'(spurious), 32'd0);
            $display("vector %0d: addr=%0h len=%0d gap=%0d err=%0d done=%0d", i, v.addr, v.len,
                     v.gap, o_error, o_done);
        end

        // Abort mid-load with reset, then load a fresh frame.
        do_reset();
        send_word(32'd300, 1'b0, "abort_addr");
        send_word(32'd4, 1'b0, "abort_len");
        send_word(32'd11, 1'b0, "abort_w0");
        send_word(32'd22, 1'b0, "abort_w1");
        rst = 1'b1;
        @(negedge clk);
        check("abort_cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("abort_ready",   32'(o_ready),   32'd0);
        check("abort_we",      32'(o_we),      32'd0);
        check("abort_done",    32'(o_done),    32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_word(32'd200, 1'b0, "reload_addr");
        send_word(32'd1, 1'b0, "reload_len");
        send_word(32'd3, 1'b0, "reload_w0");
`ifdef MEM_LOADER_CHECKSUM_EN
        send_word(32'd3, 1'b0, "reload_trailer");
`endif
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            if (o_done) ok = 1'b1;
            else @(negedge clk);
        end
        check("reload_done",   32'(o_done),    32'd1);
        check("reload_cpurst", 32'(o_cpu_rst), 32'd0);
        check("reload_mem200", mem_model[200], 32'd3);
        check("abort_mem300",  mem_model[300], 32'd11);
        check("abort_mem301",  mem_model[301], 32'd22);
        check("abort_mem302",  mem_model[302], 32'd0);
        check("reload_spurious", 32'(spurious), 32'd0);
        $display("abort sequence: done=%0d mem200=%0d", o_done, mem_model[200]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
